// File: rtl/seq_pkg.sv
// Shared definitions for the "101" pattern transmitter and its detector.
// The detector uses the same pattern constant, so both sides always match.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] SEQ_PATTERN = 3'b101;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request channel of the pattern transmitter: pattern word, length and repeat
// count, qualified by a valid/ready handshake.
interface seq_pattern_tx_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int REP_W  = 4
);

  logic [DATA_W-1:0] in_data;
  logic [LEN_W-1:0]  in_len;
  logic [REP_W-1:0]  in_repeat;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_len,
    output in_repeat,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_len,
    input  in_repeat,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/seq101_hit_counter.sv
// Counts overlapping "101" occurrences in a qualified bit stream, saturating.
// It can sit next to a detector as a golden reference for its pulse count.
module seq101_hit_counter
  import seq_pkg::*;
#(
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [HIT_W-1:0] hits
);

  logic [1:0]       history_q, history_d;
  logic [HIT_W-1:0] hitCount_q, hitCount_d;

  // Clearing wins over a same-cycle bit so no count ever spans two transfers.
  always_comb begin
    history_d  = history_q;
    hitCount_d = hitCount_q;
    if (clear) begin
      history_d  = '0;
      hitCount_d = '0;
    end else if (bit_valid) begin
      history_d = {history_q[0], bit_in};
      if (({history_q, bit_in} == SEQ_PATTERN) && (hitCount_q != '1))
        hitCount_d = hitCount_q + HIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      history_q  <= '0;
      hitCount_q <= '0;
    end else begin
      history_q  <= history_d;
      hitCount_q <= hitCount_d;
    end
  end

  assign hits = hitCount_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter feeding a "101" detector, MSB first, with
// repeat passes and a running count of the "101" hits it emits.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int REP_W  = 4,
  parameter int HIT_W  = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  seq_pattern_tx_if.slave  req,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [HIT_W-1:0] hits
);

  state_t            state_q, state_d;
  logic              inReady_q, inReady_d;
  logic [DATA_W-1:0] shiftReg_q, shiftReg_d;
  logic [DATA_W-1:0] heldData_q, heldData_d;
  logic [LEN_W-1:0]  effLen_q, effLen_d;
  logic [LEN_W-1:0]  bitCnt_q, bitCnt_d;
  logic [REP_W-1:0]  repCnt_q, repCnt_d;

  logic              accept;
  logic              lastBit;
  logic [LEN_W-1:0]  reqLen;
  logic [DATA_W-1:0] reqAligned;

  function automatic logic [LEN_W-1:0] clampLen(input logic [LEN_W-1:0] len);
    if ((len == '0) || (int'(len) > DATA_W))
      return LEN_W'(DATA_W);
    return len;
  endfunction

  // The pattern is left-justified on load so the next bit is always the MSB.
  assign reqLen     = clampLen(req.in_len);
  assign reqAligned = req.in_data << (LEN_W'(DATA_W) - reqLen);
  assign accept     = (state_q == IDLE) && inReady_q && req.in_valid;
  assign lastBit    = (bitCnt_q == LEN_W'(1));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      inReady_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inReady_q <= inReady_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (lastBit && (repCnt_q == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inReady_d = (state_d == IDLE);
  end

  always_comb begin
    x_valid = (state_q == SEND);
    x_out   = (state_q == SEND) && shiftReg_q[DATA_W-1];
    busy    = (state_q == SEND) || (state_q == DONE);
    done    = (state_q == DONE);
  end

  // A pass ending with repeats left reloads in place, so passes run back to back.
  always_comb begin
    shiftReg_d = shiftReg_q;
    heldData_d = heldData_q;
    effLen_d   = effLen_q;
    bitCnt_d   = bitCnt_q;
    repCnt_d   = repCnt_q;
    if (accept) begin
      shiftReg_d = reqAligned;
      heldData_d = reqAligned;
      effLen_d   = reqLen;
      bitCnt_d   = reqLen;
      repCnt_d   = req.in_repeat;
    end else if (state_q == SEND) begin
      if (lastBit && (repCnt_q != '0)) begin
        shiftReg_d = heldData_q;
        bitCnt_d   = effLen_q;
        repCnt_d   = repCnt_q - REP_W'(1);
      end else begin
        shiftReg_d = {shiftReg_q[DATA_W-2:0], 1'b0};
        bitCnt_d   = bitCnt_q - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shiftReg_q <= '0;
      heldData_q <= '0;
      effLen_q   <= '0;
      bitCnt_q   <= '0;
      repCnt_q   <= '0;
    end else begin
      shiftReg_q <= shiftReg_d;
      heldData_q <= heldData_d;
      effLen_q   <= effLen_d;
      bitCnt_q   <= bitCnt_d;
      repCnt_q   <= repCnt_d;
    end
  end

  seq101_hit_counter #(
    .HIT_W (HIT_W)
  ) hitCounter (
    .clk       (clk),
    .aresetn   (aresetn),
    .clear     (accept),
    .bit_valid (x_valid),
    .bit_in    (x_out),
    .hits      (hits)
  );

  assign req.in_ready = inReady_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed cases plus random requests,
// compared against a stream-level model and a small "101" detector.
module tb_seq_pattern_tx;

  logic       clk;
  logic       aresetn;
  logic       x_out;
  logic       x_valid;
  logic       busy;
  logic       done;
  logic [7:0] hits;

  int totalChecks = 0;
  int badChecks   = 0;

  bit         holdNext = 1'b0;
  logic [7:0] holdData = '0;

  logic [1:0] detHist;
  int         detHits;

  seq_pattern_tx_if #(.DATA_W(8), .LEN_W(4), .REP_W(4)) ifc ();

  seq_pattern_tx #(
    .DATA_W (8),
    .LEN_W  (4),
    .REP_W  (4),
    .HIT_W  (8)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .req     (ifc),
    .x_out   (x_out),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done),
    .hits    (hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference "101" detector clocked on the same edge, fed from x_out.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      detHist <= '0;
      detHits <= 0;
    end else if (ifc.in_valid && ifc.in_ready) begin
      detHist <= '0;
      detHits <= 0;
    end else if (x_valid) begin
      if ({detHist, x_out} == 3'b101) detHits <= detHits + 1;
      detHist <= {detHist[0], x_out};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Sends one request and checks every cycle of the transfer against a model
  // built from the emitted bit list (MSB first, passes concatenated).
  task automatic applyStimulus(input logic [7:0] d, input logic [3:0] len, input logic [3:0] rep);
    int eff;
    int expHits;
    int waitCnt;
    bit bits[$];
    eff = ((len == 0) || (len > 8)) ? 8 : int'(len);
    for (int p = 0; p <= int'(rep); p++)
      for (int i = eff - 1; i >= 0; i--)
        bits.push_back(d[i]);
    expHits = 0;
    for (int k = 2; k < bits.size(); k++)
      if (bits[k-2] && !bits[k-1] && bits[k]) expHits++;
    if (expHits > 255) expHits = 255;

    waitCnt = 0;
    while ((ifc.in_ready !== 1'b1) && (waitCnt < 300)) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("ready_wait", {31'd0, ifc.in_ready}, 32'd1);

    ifc.in_data   = d;
    ifc.in_len    = len;
    ifc.in_repeat = rep;
    ifc.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (holdNext) ifc.in_data = holdData;
    else          ifc.in_valid = 1'b0;

    foreach (bits[i]) begin
      checkOutput("x_valid", {31'd0, x_valid}, 32'd1);
      checkOutput("x_out", {31'd0, x_out}, {31'd0, bits[i]});
      checkOutput("ready_busy", {31'd0, ifc.in_ready}, 32'd0);
      checkOutput("busy", {31'd0, busy}, 32'd1);
      checkOutput("done_early", {31'd0, done}, 32'd0);
      @(negedge clk);
    end

    checkOutput("done", {31'd0, done}, 32'd1);
    checkOutput("x_valid_done", {31'd0, x_valid}, 32'd0);
    checkOutput("x_out_done", {31'd0, x_out}, 32'd0);
    checkOutput("ready_done", {31'd0, ifc.in_ready}, 32'd0);
    checkOutput("hits", {24'd0, hits}, expHits);
    checkOutput("det_hits", detHits, expHits);
    @(negedge clk);
    checkOutput("ready_after", {31'd0, ifc.in_ready}, 32'd1);
    checkOutput("done_after", {31'd0, done}, 32'd0);
    checkOutput("busy_after", {31'd0, busy}, 32'd0);
    checkOutput("hits_hold", {24'd0, hits}, expHits);
  endtask

  task automatic checkAllLow(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, ifc.in_ready}, 32'd0);
    checkOutput({tag, "_x_out"}, {31'd0, x_out}, 32'd0);
    checkOutput({tag, "_x_valid"}, {31'd0, x_valid}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_hits"}, {24'd0, hits}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    aresetn       = 1'b0;
    ifc.in_data   = '0;
    ifc.in_len    = '0;
    ifc.in_repeat = '0;
    ifc.in_valid  = 1'b0;
    #2;
    checkAllLow("reset");
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    checkOutput("ready_post_reset", {31'd0, ifc.in_ready}, 32'd1);

    applyStimulus(8'h15, 4'd5, 4'd0);
    applyStimulus(8'h02, 4'd2, 4'd2);
    applyStimulus(8'hA5, 4'd0, 4'd0);
    applyStimulus(8'hA5, 4'd12, 4'd0);
    applyStimulus(8'h01, 4'd1, 4'd3);

    // Request held valid with changing data: only the first is sent now.
    holdNext = 1'b1;
    holdData = 8'h5A;
    applyStimulus(8'h2D, 4'd6, 4'd1);
    holdNext = 1'b0;
    applyStimulus(8'h5A, 4'd6, 4'd1);

    // Reset during the third bit of a transfer aborts it with no done pulse.
    ifc.in_data   = 8'hAA;
    ifc.in_len    = 4'd8;
    ifc.in_repeat = 4'd1;
    ifc.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_abort_x_valid", {31'd0, x_valid}, 32'd1);
    checkOutput("pre_abort_x_out", {31'd0, x_out}, 32'd1);
    aresetn = 1'b0;
    #1;
    checkAllLow("abort");
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", {31'd0, ifc.in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("abort_no_done", {31'd0, done}, 32'd0);
      checkOutput("abort_no_valid", {31'd0, x_valid}, 32'd0);
      @(negedge clk);
    end
    applyStimulus(8'hB5, 4'd8, 4'd0);

    for (int t = 0; t < 25; t++) begin
      applyStimulus(8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    applyStimulus(8'hFF, 4'd8, 4'd15);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
